// File: rtl/alu_instr_sequencer_if.sv
// Control bundle between the instruction sequencer and the CPU datapath.
//   master : sequencer side. Takes Run, MemReady and IR. Drives the datapath strobes,
//            the one-hot register selects, the ALU controls and the status outputs.
//   slave  : datapath/controller side, with the opposite directions.
// Signals:
//   Run, MemReady, IR                               control inputs to the sequencer
//   PCout, MARin, IncPC, Zin, Zlowout, PCin, Read,
//   MDRin, MDRout, IRin, Yin                        single-bit datapath strobes
//   Rout, Rin                                       one-hot GPR bus-drive select and load enable
//   AluOp, AluEn                                    ALU opcode and operation strobe
//   Done, Halted, InstrCount                        completion pulse, sticky halt, instruction count
interface alu_instr_sequencer_if #(
  parameter int W    = 32,
  parameter int NREG = 16,
  parameter int OPW  = 5,
  parameter int CNTW = 16
);
  logic            Run;
  logic            MemReady;
  logic [W-1:0]    IR;
  logic            PCout;
  logic            MARin;
  logic            IncPC;
  logic            Zin;
  logic            Zlowout;
  logic            PCin;
  logic            Read;
  logic            MDRin;
  logic            MDRout;
  logic            IRin;
  logic            Yin;
  logic [NREG-1:0] Rout;
  logic [NREG-1:0] Rin;
  logic [OPW-1:0]  AluOp;
  logic            AluEn;
  logic            Done;
  logic            Halted;
  logic [CNTW-1:0] InstrCount;

  modport master (
    input  Run, MemReady, IR,
    output PCout, MARin, IncPC, Zin, Zlowout, PCin, Read, MDRin, MDRout, IRin, Yin,
    output Rout, Rin, AluOp, AluEn, Done, Halted, InstrCount
  );

  modport slave (
    output Run, MemReady, IR,
    input  PCout, MARin, IncPC, Zin, Zlowout, PCin, Read, MDRin, MDRout, IRin, Yin,
    input  Rout, Rin, AluOp, AluEn, Done, Halted, InstrCount
  );
endinterface

// File: rtl/alu_instr_sequencer.sv
// Hardwired control-step sequencer for the simple CPU datapath.
//
// Each instruction runs through six control steps:
//   T0: PC -> MAR, and PC+1 -> Z
//   T1: Z -> PC, and the memory read -> MDR (stalls here until MemReady)
//   T2: MDR -> IR
//   T3: Rb -> Y
//   T4: Rc op Y -> Z
//   T5: Z -> Ra
// The supported instructions are the register-register ALU ops "op Ra,Rb,Rc".
// The sequencer runs instructions back to back while Run is high, counts the completed
// instructions, and parks in HALT on an illegal instruction until Reset.
//
// Ports:
//   Clock  in  system clock; all state changes on the rising edge
//   Reset  in  synchronous, active-high; forces IDLE and clears Halted and InstrCount
//   bus    master modport of alu_instr_sequencer_if (strobes, selects, ALU controls, status)
module alu_instr_sequencer #(
  parameter int W          = 32,
  parameter int NREG       = 16,
  parameter int RIW        = 4,
  parameter int OPW        = 5,
  parameter int ALU_OP_MIN = 3,
  parameter int ALU_OP_MAX = 10,
  parameter int CNTW       = 16
) (
  input  logic                  Clock,
  input  logic                  Reset,
  alu_instr_sequencer_if.master bus
);

  // Bit positions of the instruction fields. They are packed from the MSB downward.
  localparam int RA_HI = W - 1 - OPW;
  localparam int RB_HI = RA_HI - RIW;
  localparam int RC_HI = RB_HI - RIW;

  localparam logic [31:0] OP_MIN_U = ALU_OP_MIN;
  localparam logic [31:0] OP_MAX_U = ALU_OP_MAX;
  localparam logic [31:0] NREG_U   = NREG;

  typedef enum logic [2:0] {
    S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_HALT
  } state_t;

  state_t          state;
  logic [CNTW-1:0] instr_count;

  logic [OPW-1:0]  opcode;
  logic [RIW-1:0]  ra;
  logic [RIW-1:0]  rb;
  logic [RIW-1:0]  rc;
  logic            legal;
  logic            unused_ir_bits;

  assign opcode = bus.IR[W-1 -: OPW];
  assign ra     = bus.IR[RA_HI -: RIW];
  assign rb     = bus.IR[RB_HI -: RIW];
  assign rc     = bus.IR[RC_HI -: RIW];

  // The IR bits below the Rc field carry no meaning for these instructions.
  assign unused_ir_bits = ^bus.IR[RC_HI-RIW:0];

  // Expand a register index into a one-hot GPR select. An index at or above NREG gives
  // all zeros, but T3 sends such an instruction to HALT before any select is driven.
  function automatic logic [NREG-1:0] onehot(input logic [RIW-1:0] idx);
    logic [NREG-1:0] sel;
    sel = '0;
    for (int i = 0; i < NREG; i++) begin
      if ({{(32-RIW){1'b0}}, idx} == $unsigned(i)) sel[i] = 1'b1;
    end
    return sel;
  endfunction

  // Legality can be judged only once IR holds the fetched word, which is from T3 onward.
  // The index checks matter only when NREG is smaller than 2**RIW.
  assign legal = ({{(32-OPW){1'b0}}, opcode} >= OP_MIN_U) &&
                 ({{(32-OPW){1'b0}}, opcode} <= OP_MAX_U) &&
                 ({{(32-RIW){1'b0}}, ra} < NREG_U) &&
                 ({{(32-RIW){1'b0}}, rb} < NREG_U) &&
                 ({{(32-RIW){1'b0}}, rc} < NREG_U);

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state       <= S_IDLE;
      instr_count <= '0;
    end else begin
      case (state)
        S_IDLE: if (bus.Run) state <= S_T0;
        S_T0:   state <= S_T1;
        S_T1:   if (bus.MemReady) state <= S_T2;
        S_T2:   state <= S_T3;
        S_T3:   state <= legal ? S_T4 : S_HALT;
        S_T4:   state <= S_T5;
        S_T5: begin
          instr_count <= instr_count + CNTW'(1);
          // Run is checked only here, so a mid-instruction drop never aborts an instruction.
          state       <= bus.Run ? S_T0 : S_IDLE;
        end
        S_HALT: state <= S_HALT;
        default: state <= S_IDLE;
      endcase
    end
  end

  // The outputs are decoded from the registered state. The T3 and T4 selects also depend
  // on the IR written at the end of T2. For that reason they cannot be computed a cycle
  // early and registered.
  always_comb begin
    bus.PCout      = 1'b0;
    bus.MARin      = 1'b0;
    bus.IncPC      = 1'b0;
    bus.Zin        = 1'b0;
    bus.Zlowout    = 1'b0;
    bus.PCin       = 1'b0;
    bus.Read       = 1'b0;
    bus.MDRin      = 1'b0;
    bus.MDRout     = 1'b0;
    bus.IRin       = 1'b0;
    bus.Yin        = 1'b0;
    bus.Rout       = '0;
    bus.Rin        = '0;
    bus.AluOp      = '0;
    bus.AluEn      = 1'b0;
    bus.Done       = 1'b0;
    bus.Halted     = (state == S_HALT);
    bus.InstrCount = instr_count;
    case (state)
      S_T0: begin
        bus.PCout = 1'b1;
        bus.MARin = 1'b1;
        bus.IncPC = 1'b1;
        bus.Zin   = 1'b1;
      end
      S_T1: begin
        // These strobes stay high through a memory stall. PCin reloading the same Z is harmless.
        bus.Zlowout = 1'b1;
        bus.PCin    = 1'b1;
        bus.Read    = 1'b1;
        bus.MDRin   = 1'b1;
      end
      S_T2: begin
        bus.MDRout = 1'b1;
        bus.IRin   = 1'b1;
      end
      S_T3: begin
        if (legal) begin
          bus.Rout = onehot(rb);
          bus.Yin  = 1'b1;
        end
      end
      S_T4: begin
        bus.Rout  = onehot(rc);
        bus.AluEn = 1'b1;
        bus.AluOp = opcode;
        bus.Zin   = 1'b1;
      end
      S_T5: begin
        bus.Zlowout = 1'b1;
        bus.Rin     = onehot(ra);
        bus.Done    = 1'b1;
      end
      default: ;
    endcase
  end

endmodule
